code_arb: RTL and testbench

Arbiter for the shared external code-memory port. It sits between the instruction cache's line-fill interface (8-word bursts) and a CPU data-load path that reads constants from code space (single words). It multiplexes both onto the one memory-side rd/valid port, locks grants for whole bursts, and aborts transfers that exceed a response timeout so no requester can hang.

---
 rtl/code_arb_if.sv | 22 ++
 rtl/code_arb.sv | 54 +++++
 tb/tb_code_arb.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/code_arb_if.sv
// code_arb_if: cache-fill, data-load and memory-side signals of the code-memory arbiter
interface code_arb_if #(parameter int ADDRLEN = 24);
    logic                c_rd;
    logic [ADDRLEN-3:0]  c_addr;
    logic                c_valid;
    logic                d_rd;
    logic [ADDRLEN-3:0]  d_addr;
    logic                d_valid;
    logic [31:0]         rdata;
    logic                m_rd;
    logic [ADDRLEN-3:0]  m_addr;
    logic                m_valid;
    logic [31:0]         m_data;
    modport master (
        input  c_rd, c_addr, d_rd, d_addr, m_valid, m_data,
        output c_valid, d_valid, rdata, m_rd, m_addr
    );
    modport slave (
        output c_rd, c_addr, d_rd, d_addr, m_valid, m_data,
        input  c_valid, d_valid, rdata, m_rd, m_addr
    );
endinterface

// File: rtl/code_arb.sv
// code_arb: burst-locking round-robin arbiter for the shared code-memory port with response timeout
module code_arb #(
    parameter int ADDRLEN = 24,
    parameter int TMO     = 255
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    code_arb_if.master bus,
    output logic       busy,
    output logic       err,
    output logic       err_port,
    input  logic       err_clr
);
    typedef enum logic [1:0] {IDLE, GNT_C, GNT_D, ABORT} state_t;
    localparam logic [7:0] TMO8 = 8'(TMO);
    state_t     state, state_nx;
    logic       lg, hold, d_req, grant, pick_d, tmo;
    logic [7:0] cnt, cnt_nx;
    always_comb begin
        d_req       = bus.d_rd & ~hold;
        grant       = state == IDLE && en && (bus.c_rd || d_req);
        pick_d      = d_req && (!bus.c_rd || !lg);
        bus.m_rd    = state == GNT_C ? bus.c_rd : state == GNT_D;
        bus.m_addr  = state == GNT_C ? bus.c_addr : state == GNT_D ? bus.d_addr : '0;
        bus.c_valid = state == GNT_C ? bus.m_valid & bus.c_rd : state == ABORT && !lg;
        bus.d_valid = state == GNT_D ? bus.m_valid : state == ABORT && lg;
        bus.rdata   = state == ABORT ? '1 : (state == GNT_C || state == GNT_D) ? bus.m_data : '0;
        // abort on the cycle the counter would reach zero, so ABORT lands exactly TMO cycles after m_rd rises
        tmo         = bus.m_rd && !bus.m_valid && cnt == 8'd1;
        cnt_nx      = (grant || bus.m_valid) ? TMO8 : bus.m_rd ? cnt - 8'd1 : cnt;
        state_nx    = state == IDLE  ? (grant ? (pick_d ? GNT_D : GNT_C) : IDLE) :
                      state == GNT_C ? (!bus.c_rd ? IDLE : tmo ? ABORT : GNT_C) :
                      state == GNT_D ? (bus.m_valid ? IDLE : tmo ? ABORT : GNT_D) :
                      IDLE;
        busy        = state != IDLE;
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= TMO8;
            lg       <= 1'b0;
            hold     <= 1'b0;
            err      <= 1'b0;
            err_port <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            lg       <= grant ? pick_d : lg;
            hold     <= bus.d_valid;
            err      <= state == ABORT ? 1'b1 : err_clr ? 1'b0 : err;
            err_port <= state == ABORT ? lg : err_port;
        end
endmodule

// File: tb/tb_code_arb.sv
// tb_code_arb: directed vectors for code_arb with hand-computed expectations
module tb_code_arb;
    localparam int AL = 24;
    logic clk = 0, rstn = 1, en = 0, err_clr = 0;
    logic busy, err, err_port;
    int n_cmp = 0, n_bad = 0;
    code_arb_if #(.ADDRLEN(AL)) bus ();
    code_arb #(.ADDRLEN(AL), .TMO(4)) dut (
        .clk(clk), .rstn(rstn), .en(en), .bus(bus),
        .busy(busy), .err(err), .err_port(err_port), .err_clr(err_clr)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #1;
    endtask
    // {m_rd, c_valid, d_valid, busy}
    function automatic logic [31:0] st();
        return 32'({bus.m_rd, bus.c_valid, bus.d_valid, busy});
    endfunction
    initial begin
        bus.c_rd = 0; bus.c_addr = '0; bus.d_rd = 0; bus.d_addr = '0; bus.m_valid = 0; bus.m_data = '0;
        #1 rstn = 0;
        settle();
        check("rst_st", st(), 32'b0000);
        check("rst_addr", 32'(bus.m_addr), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_err", 32'({err, err_port}), 0);
        cyc(); rstn = 1; en = 1;
        // cache-only 8-word burst, memory answers every cycle
        bus.c_rd = 1; bus.c_addr = 22'h100; settle();
        check("c_req_idle", st(), 32'b0000);
        cyc();
        for (int i = 0; i < 8; i++) begin
            bus.c_addr = 22'h100 + 22'(i); bus.m_valid = 1; bus.m_data = 32'hC0DE_0100 + i; settle();
            check("burst_st", st(), 32'b1101);
            check("burst_addr", 32'(bus.m_addr), 32'h100 + i);
            check("burst_data", bus.rdata, 32'hC0DE_0100 + i);
            cyc();
        end
        bus.c_rd = 0; bus.m_valid = 0; settle();
        check("burst_end", st(), 32'b0001);
        cyc();
        check("burst_idle", st(), 32'b0000);
        // simultaneous requests after reset: data first, then cache, then data again
        rstn = 0; settle(); rstn = 1;
        bus.c_rd = 1; bus.c_addr = 22'h200; bus.d_rd = 1; bus.d_addr = 22'h2AA; cyc();
        check("sim_d_addr", 32'(bus.m_addr), 32'h2AA);
        check("sim_d_st", st(), 32'b1001);
        bus.m_valid = 1; bus.m_data = 32'hDA7A_0001; settle();
        check("sim_d_valid", st(), 32'b1011);
        check("sim_d_data", bus.rdata, 32'hDA7A_0001);
        cyc(); bus.d_rd = 0; bus.m_valid = 0; settle();
        check("sim_gap", st(), 32'b0000);
        cyc();
        check("sim_c_addr", 32'(bus.m_addr), 32'h200);
        bus.m_valid = 1; bus.m_data = 32'hC0DE_0200; settle();
        check("sim_c_valid", st(), 32'b1101);
        cyc(); bus.c_addr = 22'h201; bus.m_data = 32'hC0DE_0201; settle();
        check("sim_c_data", bus.rdata, 32'hC0DE_0201);
        cyc(); bus.c_rd = 0; bus.m_valid = 0; cyc();
        bus.c_rd = 1; bus.c_addr = 22'h210; bus.d_rd = 1; bus.d_addr = 22'h2BB; cyc();
        check("alt_d_first", 32'(bus.m_addr), 32'h2BB);
        bus.m_valid = 1; bus.m_data = 32'hDA7A_0002; settle();
        check("alt_d_valid", st(), 32'b1011);
        cyc(); bus.d_rd = 0; bus.m_valid = 0; cyc();
        check("alt_c_next", 32'(bus.m_addr), 32'h210);
        bus.c_rd = 0; cyc();
        // data request arriving mid-burst waits for the burst to end
        bus.c_rd = 1; bus.c_addr = 22'h300; bus.d_addr = 22'h3DD; cyc();
        for (int i = 0; i < 8; i++) begin
            bus.c_addr = 22'h300 + 22'(i); bus.d_rd = (i >= 3); bus.m_valid = 1; bus.m_data = 32'hC0DE_0300 + i; settle();
            check("mix_addr", 32'(bus.m_addr), 32'h300 + i);
            check("mix_st", st(), 32'b1101);
            cyc();
        end
        bus.c_rd = 0; bus.m_valid = 0; settle();
        check("mix_c_drop", st(), 32'b0001);
        cyc();
        check("mix_gap", st(), 32'b0000);
        cyc();
        check("mix_d_addr", 32'(bus.m_addr), 32'h3DD);
        check("mix_d_wait", st(), 32'b1001);
        cyc(); bus.m_valid = 1; bus.m_data = 32'hDA7A_0003; settle();
        check("mix_d_valid", st(), 32'b1011);
        check("mix_d_data", bus.rdata, 32'hDA7A_0003);
        cyc(); bus.m_valid = 0; settle();
        check("hold_idle", st(), 32'b0000);
        cyc();
        check("hold_stale", st(), 32'b0000);
        bus.d_rd = 0; bus.m_valid = 1; settle();
        check("idle_mv_ignored", st(), 32'b0000);
        bus.m_valid = 0;
        // timeout on a silent memory, TMO=4
        bus.d_rd = 1; bus.d_addr = 22'h3EE; cyc();
        for (int i = 0; i < 4; i++) begin
            check("tmo_wait", st(), 32'b1001);
            cyc();
        end
        check("abort_st", st(), 32'b0011);
        check("abort_data", bus.rdata, 32'hFFFF_FFFF);
        check("abort_err_pre", 32'(err), 0);
        bus.d_rd = 0; cyc();
        check("abort_idle", st(), 32'b0000);
        check("err_set", 32'({err, err_port}), 32'b11);
        err_clr = 1; cyc(); err_clr = 0;
        check("err_clr", 32'(err), 0);
        // en low mid-burst: burst completes, pending data stays ungranted
        bus.c_rd = 1; bus.c_addr = 22'h400; bus.d_addr = 22'h4DD; cyc();
        for (int i = 0; i < 8; i++) begin
            if (i == 2) en = 0;
            bus.c_addr = 22'h400 + 22'(i); bus.d_rd = (i >= 4); bus.m_valid = 1; bus.m_data = 32'hC0DE_0400 + i; settle();
            check("en0_burst", st(), 32'b1101);
            cyc();
        end
        bus.c_rd = 0; bus.m_valid = 0; cyc();
        for (int i = 0; i < 3; i++) begin
            check("en0_hold", st(), 32'b0000);
            cyc();
        end
        en = 1; cyc();
        check("en1_grant", 32'(bus.m_addr), 32'h4DD);
        check("en1_st", st(), 32'b1001);
        bus.m_valid = 1; cyc(); bus.d_rd = 0; bus.m_valid = 0; cyc();
        // async reset during cache word 5
        bus.c_rd = 1; bus.c_addr = 22'h500; cyc();
        for (int i = 0; i < 5; i++) begin
            bus.c_addr = 22'h500 + 22'(i); bus.m_valid = 1; bus.m_data = 32'hC0DE_0500 + i; cyc();
        end
        bus.c_addr = 22'h505; bus.m_data = 32'hC0DE_0505; settle();
        check("pre_rst_st", st(), 32'b1101);
        rstn = 0; settle();
        check("rst_mid_st", st(), 32'b0000);
        check("rst_mid_addr", 32'(bus.m_addr), 0);
        cyc(); rstn = 1; settle();
        check("rst_idle", st(), 32'b0000);
        cyc();
        check("rst_resume_addr", 32'(bus.m_addr), 32'h505);
        check("rst_resume_st", st(), 32'b1101);
        check("rst_resume_data", bus.rdata, 32'hC0DE_0505);
        cyc(); bus.c_rd = 0; bus.m_valid = 0; cyc();
        check("final_idle", st(), 32'b0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
